// File: rtl/timer_controller.sv
// timer_controller: debounced start/pause/clear FSM for a min/sec counter; define TIMER_ALARM_EN for the DONE blink alarm
module timer_controller #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned CLEAR_CYCLES      = 200000000,
    parameter int unsigned ALARM_HALF_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_dir,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       finish,
    output logic       cnt_enable,
    output logic       cnt_forward,
    output logic       cnt_reset,
    output logic       inc_seconds,
    output logic       inc_minutes,
    output logic [2:0] state,
    output logic       alarm
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [2:0] {CLEAR, IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, next_state;
    logic [4:0] btn, sync1, sync2, db;
    logic [2:0] db_q, press;
    logic [DW-1:0] db_cnt [5];
    logic [2:0] fin_sync;
    logic fin_evt;
    logic [31:0] clr_cnt;
    assign btn = {btn_min, btn_sec, btn_dir, btn_clear, btn_start};
    assign press = db[2:0] & ~db_q;
    assign fin_evt = fin_sync[1] & ~fin_sync[2];
    assign state = state_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db <= '0;
            db_q <= '0;
            fin_sync <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q <= db[2:0];
            fin_sync <= {fin_sync[1:0], finish};
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + DW'(1);
            end
        end
    end
    // clear beats finish, finish beats start
    always_comb begin
        next_state = CLEAR;
        case (state_q)
            CLEAR:   next_state = (!press[1] && clr_cnt == CLEAR_CYCLES - 1) ? IDLE : CLEAR;
            IDLE:    next_state = press[1] ? CLEAR : press[0] ? RUN : IDLE;
            RUN:     next_state = press[1] ? CLEAR : fin_evt ? DONE : press[0] ? PAUSE : RUN;
            PAUSE:   next_state = press[1] ? CLEAR : press[0] ? RUN : PAUSE;
            DONE:    next_state = (press[1] || press[0]) ? CLEAR : DONE;
            default: next_state = CLEAR;
        endcase
    end
    // outputs decode the next state so they line up with the registered state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
            cnt_reset <= 1'b1;
            cnt_enable <= 1'b0;
            cnt_forward <= 1'b1;
            inc_seconds <= 1'b0;
            inc_minutes <= 1'b0;
        end else begin
            state_q <= next_state;
            clr_cnt <= (state_q == CLEAR && next_state == CLEAR && !press[1]) ? clr_cnt + 32'd1 : '0;
            cnt_reset <= next_state == CLEAR;
            cnt_enable <= next_state == RUN;
            cnt_forward <= (state_q == IDLE && press[2]) ? ~cnt_forward : cnt_forward;
            inc_seconds <= db[3] && (next_state == IDLE || next_state == PAUSE);
            inc_minutes <= db[4] && (next_state == IDLE || next_state == PAUSE);
        end
    end
`ifdef TIMER_ALARM_EN
    logic [31:0] alarm_cnt;
    always_ff @(posedge clk) begin
        if (!reset || next_state != DONE) begin
            alarm <= 1'b0;
            alarm_cnt <= '0;
        end else if (state_q != DONE) begin
            alarm <= 1'b1;
            alarm_cnt <= '0;
        end else if (alarm_cnt == ALARM_HALF_PERIOD - 1) begin
            alarm <= ~alarm;
            alarm_cnt <= '0;
        end else alarm_cnt <= alarm_cnt + 32'd1;
    end
`else
    assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: directed scoreboard bench for timer_controller
module tb_timer_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic finish = 1'b0;
    logic [4:0] btns = '0;
    logic cnt_enable, cnt_forward, cnt_reset, inc_seconds, inc_minutes, alarm;
    logic [2:0] state;
    int checks = 0;
    int errors = 0;
    int n;
    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    timer_controller #(.DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(8), .ALARM_HALF_PERIOD(3)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btns[0]), .btn_clear(btns[1]), .btn_dir(btns[2]),
        .btn_sec(btns[3]), .btn_min(btns[4]), .finish(finish),
        .cnt_enable(cnt_enable), .cnt_forward(cnt_forward), .cnt_reset(cnt_reset),
        .inc_seconds(inc_seconds), .inc_minutes(inc_minutes), .state(state), .alarm(alarm)
    );

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic got(input int obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %0d expected nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic press(input int i, input int k);
        btns[i] = 1'b1;
        tick(k);
        btns[i] = 1'b0;
    endtask

    task automatic wait_state(input int s, input int lim, output int cnt);
        cnt = 0;
        while (int'(state) != s && cnt < lim) begin
            tick(1);
            cnt++;
        end
    endtask

    initial begin
        // reset values
        expect_v("rst_state", 0); expect_v("rst_cnt_reset", 1); expect_v("rst_enable", 0);
        expect_v("rst_forward", 1); expect_v("rst_inc", 0); expect_v("rst_alarm", 0);
        tick(2);
        got(int'(state)); got(int'(cnt_reset)); got(int'(cnt_enable));
        got(int'(cnt_forward)); got(int'(inc_seconds | inc_minutes)); got(int'(alarm));
        // clear phase length after release
        reset = 1'b1;
        expect_v("clear_len", 8);
        n = 0;
        while (cnt_reset && n < 20) begin
            tick(1);
            n++;
        end
        got(n);
        expect_v("idle_state", 1); expect_v("idle_enable", 0); expect_v("idle_forward", 1);
        got(int'(state)); got(int'(cnt_enable)); got(int'(cnt_forward));
        // short glitch on start is filtered
        expect_v("short_start", 1);
        press(0, 3);
        tick(8);
        got(int'(state));
        // long start press enters RUN once
        expect_v("start_not_yet", 1); expect_v("start_run", 2); expect_v("run_enable", 1);
        expect_v("run_once", 2); expect_v("run_once_en", 1);
        btns[0] = 1'b1;
        tick(6); got(int'(state));
        tick(1); got(int'(state)); got(int'(cnt_enable));
        tick(3);
        btns[0] = 1'b0;
        tick(10); got(int'(state)); got(int'(cnt_enable));
        // finish pulse -> DONE and alarm pattern
        expect_v("fin_sync_delay", 2);
        finish = 1'b1;
        tick(2); got(int'(state));
        finish = 1'b0;
        expect_v("done_state", 4); expect_v("done_enable", 0);
        tick(1); got(int'(state)); got(int'(cnt_enable));
        for (int i = 0; i < 7; i++) begin
`ifdef TIMER_ALARM_EN
            expect_v("alarm_seq", (i % 6) < 3 ? 1 : 0);
`else
            expect_v("alarm_seq", 0);
`endif
            if (i > 0) tick(1);
            got(int'(alarm));
        end
        // start in DONE -> CLEAR; a clear press inside CLEAR restarts the count
        expect_v("done_to_clear", 0); expect_v("clear_alarm", 0); expect_v("clear_restart_len", 15);
        press(0, 7);
        got(int'(state)); got(int'(alarm));
        btns[1] = 1'b1;
        wait_state(1, 40, n);
        got(n);
        btns[1] = 1'b0;
        tick(8);
        // clear and finish_evt on the same cycle in RUN
        expect_v("prio_run", 2); expect_v("prio_clear", 0); expect_v("prio_recover", 8);
        press(0, 7);
        got(int'(state));
        tick(8);
        btns[1] = 1'b1;
        tick(4);
        finish = 1'b1;
        tick(3);
        got(int'(state));
        finish = 1'b0;
        btns[1] = 1'b0;
        wait_state(1, 30, n);
        got(n);
        tick(8);
        // PAUSE: set levels and ignored direction
        expect_v("pause_run", 2); expect_v("pause_state", 3); expect_v("pause_enable", 0);
        press(0, 7);
        got(int'(state));
        tick(8);
        press(0, 7);
        got(int'(state)); got(int'(cnt_enable));
        tick(8);
        expect_v("sec_lat", 0); expect_v("sec_on", 1); expect_v("sec_hold", 1);
        expect_v("sec_rel_lat", 1); expect_v("sec_off", 0);
        btns[3] = 1'b1;
        tick(6); got(int'(inc_seconds));
        tick(1); got(int'(inc_seconds));
        tick(3); got(int'(inc_seconds));
        btns[3] = 1'b0;
        tick(6); got(int'(inc_seconds));
        tick(1); got(int'(inc_seconds));
        expect_v("pause_dir_fwd", 1); expect_v("pause_dir_state", 3);
        press(2, 7);
        tick(8);
        got(int'(cnt_forward)); got(int'(state));
        // clear from PAUSE, then direction toggle in IDLE
        expect_v("pause_clear", 0); expect_v("pause_clear_len", 8); expect_v("idle_dir", 0);
        press(1, 7);
        got(int'(state));
        wait_state(1, 30, n);
        got(n);
        tick(8);
        press(2, 7);
        got(int'(cnt_forward));
        tick(8);
        expect_v("idle_min", 1); expect_v("idle_sec_low", 0);
        btns[4] = 1'b1;
        tick(7);
        got(int'(inc_minutes)); got(int'(inc_seconds));
        btns[4] = 1'b0;
        tick(8);
        // reset asserted mid-RUN
        expect_v("mid_run", 2); expect_v("mr_state", 0); expect_v("mr_enable", 0);
        expect_v("mr_cnt_reset", 1); expect_v("mr_forward", 1); expect_v("mr_clear_len", 8);
        expect_v("mr_final_idle", 1);
        press(0, 7);
        got(int'(state));
        tick(3);
        reset = 1'b0;
        tick(1);
        got(int'(state)); got(int'(cnt_enable)); got(int'(cnt_reset)); got(int'(cnt_forward));
        reset = 1'b1;
        wait_state(1, 30, n);
        got(n);
        tick(10);
        got(int'(state));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clk cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter CLEAR_CYCLES, default 200000000, is the number of cycles cnt_reset is held so a 1 Hz-clocked counter samples it.
REQ-003 Parameter ALARM_HALF_PERIOD, default 25000000, is the number of cycles per alarm toggle.
REQ-004 Port clk, input, 1 bit: the single system clock (100 MHz); every register is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port btn_start, input, 1 bit: raw start/pause button, asynchronous to clk.
REQ-007 Port btn_clear, input, 1 bit: raw clear button, asynchronous to clk.
REQ-008 Port btn_dir, input, 1 bit: raw count-direction toggle button, asynchronous to clk.
REQ-009 Port btn_sec / btn_min, input, 1 bit each: raw seconds/minutes set buttons, asynchronous to clk.
REQ-010 Port finish, input, 1 bit: terminal flag from the minutes/seconds counter, asynchronous to clk.
REQ-011 Port cnt_enable, output, 1 bit: counter enable.
REQ-012 Port cnt_forward, output, 1 bit: counter direction (1 = up).
REQ-013 Port cnt_reset, output, 1 bit: counter clear, active-high.
REQ-014 Port inc_seconds / inc_minutes, output, 1 bit each: counter set-increment levels.
REQ-015 Port state, output, 3 bits: current FSM state code.
REQ-016 Port alarm, output, 1 bit: blinking alarm indicator.

Function
REQ-017 Every button input SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-018 Each button SHALL produce a one-cycle press pulse on the rising edge of its debounced level; releases produce no pulse.
REQ-019 finish SHALL be 2-flop synchronized; finish_evt is a one-cycle pulse on its synchronized rising edge (no debounce).
REQ-020 States: CLEAR=0, IDLE=1, RUN=2, PAUSE=3, DONE=4; codes 5-7 SHALL transition to CLEAR on the next cycle.
REQ-021 CLEAR: cnt_reset=1; a 32-bit counter runs; after exactly CLEAR_CYCLES cycles in CLEAR, go to IDLE.
REQ-022 IDLE: start pulse -> RUN; clear pulse -> CLEAR; dir pulse toggles cnt_forward.
REQ-023 RUN: cnt_enable=1; finish_evt -> DONE; start pulse -> PAUSE; clear pulse -> CLEAR.
REQ-024 PAUSE: start pulse -> RUN; clear pulse -> CLEAR.
REQ-025 DONE: start or clear pulse -> CLEAR.
REQ-026 Priority on simultaneous events: clear > finish_evt > start; a clear pulse arriving while in CLEAR SHALL restart the CLEAR_CYCLES count.
REQ-027 cnt_enable SHALL be 1 only in RUN; cnt_reset SHALL be 1 only in CLEAR.
REQ-028 inc_seconds/inc_minutes SHALL equal the debounced btn_sec/btn_min levels in IDLE and PAUSE, and 0 in all other states.
REQ-029 cnt_forward SHALL change only in IDLE; dir pulses in other states are ignored.
REQ-030 All outputs SHALL be registered (one-cycle latency from state change).

Reset
REQ-031 When reset=0 at a clk edge: state=CLEAR, clear counter=0, cnt_reset=1, cnt_enable=0, cnt_forward=1, inc_*=0, alarm=0, debounced levels=0, debounce counters=0, synchronizers=0.
REQ-032 Reset asserted mid-RUN SHALL stop counting on the next edge; no press pulse or finish_evt is generated from pre-reset history.

Configuration
REQ-033 Macro TIMER_ALARM_EN defined: in DONE, alarm toggles every ALARM_HALF_PERIOD cycles starting at 1 on DONE entry, and is 0 in all other states.
REQ-034 Macro TIMER_ALARM_EN undefined: the alarm logic is absent, alarm is tied to 0, and DONE behaviour is otherwise unchanged.

Verification (DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8, ALARM_HALF_PERIOD=3)
REQ-035 Release reset -> cnt_reset=1 for exactly 8 cycles, then state=1, cnt_enable=0, cnt_forward=1.
REQ-036 From IDLE, hold btn_start high for 3 cycles only -> no transition; hold it for 10 cycles -> state=2 and cnt_enable=1, entered once only.
REQ-037 In RUN, pulse finish high for 2 cycles -> state=4 and cnt_enable=0; with TIMER_ALARM_EN, alarm reads 1,1,1,0,0,0,1 over cycles.
REQ-038 In RUN, debounced clear and finish_evt fire on the same cycle -> state=0 (not DONE).
REQ-039 In PAUSE, hold btn_sec -> inc_seconds=1 until release; press btn_dir -> cnt_forward stays 1; in IDLE, press btn_dir -> cnt_forward=0.
REQ-040 Force reset=0 mid-RUN for 1 cycle -> next edge shows state=0, cnt_enable=0, cnt_reset=1.
